intersection_phase_scheduler: RTL and testbench

Timed two-road intersection scheduler that shares the crossing between a north-south (NS) and an east-west (EW) approach.
- Latches vehicle calls from each approach's sensor.
- Sequences green -> yellow -> all-red clearance per approach.
- Enforces minimum green, gap-out and max-out rules.
- Drives one-hot lamp outputs plus an encoded phase for debug and downstream display logic.

---
 rtl/intersection_pkg.sv | 47 ++++
 rtl/intersection_phase_scheduler_phase_timer.sv | 27 ++
 rtl/intersection_phase_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_intersection_phase_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/intersection_pkg.sv
// Shared types for the intersection phase scheduler: phase encoding,
// lamp bundle and the phase-to-lamp decode used by the top level.
package intersection_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        NS_CLEAR  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        EW_CLEAR  = 3'd5,
        WALK      = 3'd6
    } phase_e;

    typedef struct packed {
        logic green;
        logic yellow;
        logic red;
    } lamp_t;

    localparam lamp_t LAMP_GREEN  = '{green: 1'b1, yellow: 1'b0, red: 1'b0};
    localparam lamp_t LAMP_YELLOW = '{green: 1'b0, yellow: 1'b1, red: 1'b0};
    localparam lamp_t LAMP_RED    = '{green: 1'b0, yellow: 1'b0, red: 1'b1};

    // NS head shows its own green/yellow only in NS phases; red otherwise.
    function automatic lamp_t ns_lamp(input phase_e p);
        lamp_t l;
        case (p)
            NS_GREEN:  l = LAMP_GREEN;
            NS_YELLOW: l = LAMP_YELLOW;
            default:   l = LAMP_RED;
        endcase
        return l;
    endfunction

    // EW head mirrors the NS decode.
    function automatic lamp_t ew_lamp(input phase_e p);
        lamp_t l;
        case (p)
            EW_GREEN:  l = LAMP_GREEN;
            EW_YELLOW: l = LAMP_YELLOW;
            default:   l = LAMP_RED;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/intersection_phase_scheduler_phase_timer.sv
// Phase timer: clears on request, counts up once per cycle and holds at a
// caller-supplied saturation value so it can never wrap. 'done' flags that
// the count has reached a caller-supplied compare value.
module phase_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [CNT_W-1:0] sat_val,
    input  logic [CNT_W-1:0] done_val,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    // Count register: reset/clear to zero, otherwise climb until saturated.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count != sat_val) begin
            count <= count + CNT_W'(1);
        end
    end

    assign done = (count == done_val);

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Two-road intersection phase scheduler (NS / EW approaches).
// Green -> yellow -> all-red sequencing with minimum green, gap-out and
// max-out. Optional pedestrian walk phase is enabled by defining the macro
// PED_WALK_EN; without it the ped ports do not exist and WALK is unreachable.
module intersection_phase_scheduler
    import intersection_pkg::*;
#(
    parameter int GREEN_MIN = 8,
    parameter int GREEN_MAX = 32,
    parameter int YELLOW_T  = 4,
    parameter int ALLRED_T  = 2,
    parameter int CNT_W     = 6,
    parameter int WALK_T    = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ns_req,
    input  logic       ew_req,
    output logic       ns_green,
    output logic       ns_yellow,
    output logic       ns_red,
    output logic       ew_green,
    output logic       ew_yellow,
    output logic       ew_red,
    output logic [2:0] phase
`ifdef PED_WALK_EN
    ,
    input  logic       ped_req,
    output logic       ped_walk
`endif
);

    localparam int MAX_T_A = (GREEN_MAX > YELLOW_T) ? GREEN_MAX : YELLOW_T;
    localparam int MAX_T_B = (ALLRED_T > WALK_T) ? ALLRED_T : WALK_T;
    localparam int MAX_T   = (MAX_T_A > MAX_T_B) ? MAX_T_A : MAX_T_B;

    if (GREEN_MIN < 1) begin : g_chk_green_min
        $error("GREEN_MIN must be >= 1");
    end
    if (GREEN_MAX < GREEN_MIN) begin : g_chk_green_max
        $error("GREEN_MAX must be >= GREEN_MIN");
    end
    if (YELLOW_T < 1 || ALLRED_T < 1 || WALK_T < 1) begin : g_chk_times
        $error("YELLOW_T, ALLRED_T and WALK_T must be >= 1");
    end
    if (CNT_W < 1 || (MAX_T - 1) >= (1 << CNT_W)) begin : g_chk_cnt_w
        $error("CNT_W too narrow for the longest phase");
    end

    localparam logic [CNT_W-1:0] GMIN_M1 = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_M1 = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_M1   = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] WALK_M1 = CNT_W'(WALK_T - 1);

    phase_e           state;
    phase_e           next_state;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] sat_val;
    logic [CNT_W-1:0] done_val;
    logic             timer_done;
    logic             ns_call;
    logic             ew_call;
    logic             ped_pending;
    logic             walk_to_ew;
    lamp_t            ns_l;
    lamp_t            ew_l;

    phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (next_state != state),
        .sat_val (sat_val),
        .done_val(done_val),
        .count   (timer),
        .done    (timer_done)
    );

`ifdef PED_WALK_EN
    logic ped_call;
    logic walk_dir;

    // Pedestrian call latch and the green to resume after WALK.
    always_ff @(posedge clk) begin
        if (rst) begin
            ped_call <= 1'b0;
            walk_dir <= 1'b0;
        end else begin
            if (next_state == WALK && state != WALK) begin
                ped_call <= 1'b0;
                walk_dir <= (state == NS_CLEAR);
            end else if (ped_req) begin
                ped_call <= 1'b1;
            end
        end
    end

    assign ped_pending = ped_call;
    assign walk_to_ew  = walk_dir;
    assign ped_walk    = (state == WALK);
`else
    assign ped_pending = 1'b0;
    assign walk_to_ew  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= NS_GREEN;
        end else begin
            state <= next_state;
        end
    end

    // Next-state rules plus the timer's saturation and expiry values per phase.
    always_comb begin
        next_state = state;
        sat_val    = GMAX_M1;
        done_val   = GMAX_M1;
        case (state)
            NS_GREEN: begin
                if (timer >= GMIN_M1 && (ew_call || ped_pending) && (!ns_req || timer_done)) begin
                    next_state = NS_YELLOW;
                end
            end
            NS_YELLOW: begin
                sat_val  = YEL_M1;
                done_val = YEL_M1;
                if (timer_done) next_state = NS_CLEAR;
            end
            NS_CLEAR: begin
                sat_val  = AR_M1;
                done_val = AR_M1;
                if (timer_done) next_state = ped_pending ? WALK : EW_GREEN;
            end
            EW_GREEN: begin
                if (timer >= GMIN_M1 && (ns_call || ped_pending) && (!ew_req || timer_done)) begin
                    next_state = EW_YELLOW;
                end
            end
            EW_YELLOW: begin
                sat_val  = YEL_M1;
                done_val = YEL_M1;
                if (timer_done) next_state = EW_CLEAR;
            end
            EW_CLEAR: begin
                sat_val  = AR_M1;
                done_val = AR_M1;
                if (timer_done) next_state = ped_pending ? WALK : NS_GREEN;
            end
            WALK: begin
                sat_val  = WALK_M1;
                done_val = WALK_M1;
                if (timer_done) next_state = walk_to_ew ? EW_GREEN : NS_GREEN;
            end
            default: begin
                next_state = NS_GREEN;
            end
        endcase
    end

    // Vehicle call latches; entering an approach's green serves its call.
    always_ff @(posedge clk) begin
        if (rst) begin
            ns_call <= 1'b0;
            ew_call <= 1'b0;
        end else begin
            if (next_state == NS_GREEN && state != NS_GREEN) begin
                ns_call <= 1'b0;
            end else if (ns_req) begin
                ns_call <= 1'b1;
            end
            if (next_state == EW_GREEN && state != EW_GREEN) begin
                ew_call <= 1'b0;
            end else if (ew_req) begin
                ew_call <= 1'b1;
            end
        end
    end

    assign ns_l      = ns_lamp(state);
    assign ew_l      = ew_lamp(state);
    assign ns_green  = ns_l.green;
    assign ns_yellow = ns_l.yellow;
    assign ns_red    = ns_l.red;
    assign ew_green  = ew_l.green;
    assign ew_yellow = ew_l.yellow;
    assign ew_red    = ew_l.red;
    assign phase     = state;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Bench for intersection_phase_scheduler: directed timing scenarios plus a
// randomized run compared against a phase/time-in-phase reference model.
module tb_intersection_phase_scheduler;

    localparam int GMIN = 8;
    localparam int GMAX = 32;
    localparam int YEL  = 4;
    localparam int AR   = 2;
    localparam int WLK  = 6;

    logic       clk;
    logic       rst;
    logic       ns_req;
    logic       ew_req;
    logic       ped_req;
    logic       ns_green, ns_yellow, ns_red;
    logic       ew_green, ew_yellow, ew_red;
    logic [2:0] phase;
    logic       ped_walk;

    int n_checks;
    int n_fail;

    // reference model: phase number, cycles spent in it, latched calls
    int m_phase;
    int m_time;
    bit m_ns_call;
    bit m_ew_call;
    bit m_ped_call;
    bit m_walk_to_ew;

    intersection_phase_scheduler dut (
        .clk      (clk),
        .rst      (rst),
        .ns_req   (ns_req),
        .ew_req   (ew_req),
        .ns_green (ns_green),
        .ns_yellow(ns_yellow),
        .ns_red   (ns_red),
        .ew_green (ew_green),
        .ew_yellow(ew_yellow),
        .ew_red   (ew_red),
        .phase    (phase)
`ifdef PED_WALK_EN
        ,
        .ped_req  (ped_req),
        .ped_walk (ped_walk)
`endif
    );

`ifndef PED_WALK_EN
    assign ped_walk = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int lamps_for(input int p);
        // {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}
        case (p)
            0:       return 6'b100_001;
            1:       return 6'b010_001;
            3:       return 6'b001_100;
            4:       return 6'b001_010;
            default: return 6'b001_001;
        endcase
    endfunction

    // Advance the model by one clock using the inputs about to be sampled.
    task automatic modelStep(input bit n, input bit e, input bit p, input bit r);
        int nxt;
        bit ped_on;
`ifdef PED_WALK_EN
        ped_on = 1'b1;
`else
        ped_on = 1'b0;
`endif
        if (r) begin
            m_phase = 0; m_time = 0;
            m_ns_call = 0; m_ew_call = 0; m_ped_call = 0; m_walk_to_ew = 0;
            return;
        end
        nxt = m_phase;
        case (m_phase)
            0: if (m_time >= GMIN - 1 && (m_ew_call || m_ped_call) && (!n || m_time == GMAX - 1)) nxt = 1;
            1: if (m_time == YEL - 1) nxt = 2;
            2: if (m_time == AR - 1) nxt = m_ped_call ? 6 : 3;
            3: if (m_time >= GMIN - 1 && (m_ns_call || m_ped_call) && (!e || m_time == GMAX - 1)) nxt = 4;
            4: if (m_time == YEL - 1) nxt = 5;
            5: if (m_time == AR - 1) nxt = m_ped_call ? 6 : 0;
            default: if (m_time == WLK - 1) nxt = m_walk_to_ew ? 3 : 0;
        endcase
        if (nxt == 6 && m_phase != 6) m_walk_to_ew = (m_phase == 2);
        m_ns_call  = (nxt == 0 && m_phase != 0) ? 1'b0 : (m_ns_call | n);
        m_ew_call  = (nxt == 3 && m_phase != 3) ? 1'b0 : (m_ew_call | e);
        m_ped_call = (nxt == 6 && m_phase != 6) ? 1'b0 : (m_ped_call | (p & ped_on));
        if (nxt != m_phase) m_time = 0;
        else if ((m_phase == 0 || m_phase == 3) && m_time == GMAX - 1) m_time = GMAX - 1;
        else m_time = m_time + 1;
        m_phase = nxt;
    endtask

    // Drive one cycle of inputs, step the model, then compare at the next negedge.
    task automatic applyStimulus(input bit n, input bit e, input bit p, input bit r);
        ns_req  = n;
        ew_req  = e;
        ped_req = p;
        rst     = r;
        modelStep(n, e, p, r);
        @(negedge clk);
        checkOutput("phase", int'(phase), m_phase);
        checkOutput("lamps", int'({ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red}),
                    lamps_for(m_phase));
        checkOutput("walk", int'(ped_walk), int'(m_phase == 6));
    endtask

    task automatic doReset();
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
    endtask

    function automatic int plan_phase(input int k, input int grn_end, input bit walk);
        if (k < grn_end) return 0;
        if (k < grn_end + YEL) return 1;
        if (k < grn_end + YEL + AR) return 2;
        if (walk && k < grn_end + YEL + AR + WLK) return 6;
        return 3;
    endfunction

    initial begin
        int  guard;
        bit  n, e, p, r;
        n_checks = 0;
        n_fail   = 0;
        ns_req = 0; ew_req = 0; ped_req = 0; rst = 1;
        modelStep(0, 0, 0, 1);
        @(negedge clk);
        checkOutput("reset_phase", int'(phase), 0);
        checkOutput("reset_lamps", int'({ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red}), 6'b100_001);
        checkOutput("reset_walk", int'(ped_walk), 0);

        // EW demand only: gap-out at min green
        doReset();
        for (int k = 0; k < 20; k++) begin
            checkOutput("plan_gapout", int'(phase), plan_phase(k, GMIN, 0));
            applyStimulus(0, 1, 0, 0);
        end

        // both approaches held: max-out
        doReset();
        for (int k = 0; k < 40; k++) begin
            checkOutput("plan_maxout", int'(phase), plan_phase(k, GMAX, 0));
            applyStimulus(1, 1, 0, 0);
        end

        // no demand: rest in NS green
        doReset();
        for (int k = 0; k < 100; k++) applyStimulus(0, 0, 0, 0);
        checkOutput("rest_green", int'(ns_green), 1);

        // single-cycle EW pulse is latched
        doReset();
        for (int k = 0; k < 20; k++) begin
            checkOutput("plan_pulse", int'(phase), plan_phase(k, GMIN, 0));
            applyStimulus(0, k == 3, 0, 0);
        end

        // reset during EW yellow (ns demand pushes EW out of green)
        guard = 0;
        while (m_phase != 4 && guard < 200) begin
            applyStimulus(1, 0, 0, 0);
            guard++;
        end
        checkOutput("reach_ew_yellow", int'(phase), 4);
        applyStimulus(1, 1, 0, 1);
        checkOutput("reset_mid_phase", int'(phase), 0);
        checkOutput("reset_mid_green", int'(ns_green), 1);
        // calls cleared: without fresh demand NS must rest past min green
        for (int k = 0; k < GMIN + 4; k++) applyStimulus(0, 0, 0, 0);
        checkOutput("calls_cleared", int'(phase), 0);

`ifdef PED_WALK_EN
        doReset();
        for (int k = 0; k < 24; k++) begin
            checkOutput("plan_walk", int'(phase), plan_phase(k, GMIN, 1));
            applyStimulus(0, 0, k == 2, 0);
        end
`endif

        // randomized run against the model
        doReset();
        n = 0; e = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0) n = ~n;
            if ($urandom_range(0, 7) == 0) e = ~e;
            p = ($urandom_range(0, 39) == 0);
            r = ($urandom_range(0, 299) == 0);
            applyStimulus(n, e, p, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
